// File: rtl/if_prefetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch prefetch unit.
package if_prefetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] PC_INCR          = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_prefetch_unit_fifo.sv
// Synchronous FIFO with flush and a registered head; a push into an empty
// queue becomes visible on the following cycle.
module if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg, wr_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] head_reg;
  logic             do_push, do_pop;

  assign do_pop      = pop && (count_reg != '0);
  assign do_push     = push && ((count_reg != DEPTH_CNT) || do_pop);
  assign rd_ptr_next = rd_ptr_reg + AW'(do_pop);
  assign count       = count_reg;
  assign head        = head_reg;

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else if (flush) begin
      // head_reg deliberately kept so the presented PC holds after a flush
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_reg + CW'(do_push) - CW'(do_pop);
      if (count_reg != CW'(do_pop)) head_reg <= mem[rd_ptr_next];
      else if (do_push)             head_reg <= push_data;
    end
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Fetch front end: owns the PC, issues credit-limited memory requests and
// queues in-order responses for IF_ID, with redirect flush and stall hold.
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic          reset_q_reg;
  logic [31:0]   fetch_pc_reg, pc_tag_reg;
  logic [CW-1:0] outstanding_reg, drop_cnt_reg, outstanding_next;
  logic [CW-1:0] q_count;
  logic [CW:0]   credit_sum;
  logic          accept, keep, pop;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  // Requests in flight plus queued entries never exceed the queue depth,
  // so every response always has a free slot.
  assign credit_sum     = {1'b0, outstanding_reg} + {1'b0, q_count};
  assign imem_req_valid = !reset_q_reg && !redirect && (credit_sum < {1'b0, DEPTH_CNT});
  assign imem_req_addr  = fetch_pc_reg;
  assign accept         = imem_req_valid && imem_req_ready;

  assign keep             = imem_rsp_valid && (drop_cnt_reg == '0) && !redirect;
  assign outstanding_next = outstanding_reg + CW'(accept) - CW'(imem_rsp_valid);
  assign push_entry       = '{pc: pc_tag_reg, data: imem_rsp_data};

  assign inst_valid = (q_count != '0);
  assign pop        = inst_valid && !stall;
  assign inst_pc    = head.pc;
  assign inst_data  = inst_valid ? head.data : (reset_q_reg ? 32'h0 : NOP_INST);

  always_ff @(posedge clk) begin
    reset_q_reg <= reset;
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      pc_tag_reg      <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      if (redirect) begin
        // Everything still in flight after this cycle belongs to the old path
        fetch_pc_reg <= align_pc(redirect_pc);
        pc_tag_reg   <= align_pc(redirect_pc);
        drop_cnt_reg <= outstanding_next;
      end else begin
        if (accept) fetch_pc_reg <= fetch_pc_reg + PC_INCR;
        if (imem_rsp_valid) begin
          if (drop_cnt_reg != '0) drop_cnt_reg <= drop_cnt_reg - CW'(1);
          else                    pc_tag_reg   <= pc_tag_reg + PC_INCR;
        end
      end
    end
  end

  if_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (keep),
    .push_data (push_entry),
    .pop       (pop),
    .count     (q_count),
    .head      (head)
  );

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit with an in-order, fixed-latency memory model.
module tb_if_prefetch_unit;
  import if_prefetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;

  int total = 0;
  int bad   = 0;
  int lat   = 1;
  int cyc   = 0;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;
  pend_t pend[$];

  always #5 clk = ~clk;

  if_prefetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory: answers each accepted request exactly lat cycles later, in order
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      pend.delete();
      imem_rsp_valid <= 1'b0;
    end else begin
      if (imem_req_valid && imem_req_ready) pend.push_back('{cyc + lat - 1, imem_req_addr});
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
    $display("check %-14s obs=%h exp=%h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
    $display("check %-14s obs=%b exp=%b", tag, obs, exp);
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n = 0;
    while (inst_valid !== 1'b1 && n < max) begin
      step();
      n++;
    end
    chk1(tag, inst_valid, 1'b1);
  endtask

  task automatic do_reset(input int l);
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; imem_req_ready = 1'b1; lat = l;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values, then streaming with a 1-cycle memory
    step(); step();
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    reset = 1'b0;
    step();
    chk1("a_req_valid", imem_req_valid, 1'b1);
    chk("a_req_addr", imem_req_addr, 32'h0);
    step();
    chk1("a_lat_valid", inst_valid, 1'b0);
    chk("a_nop", inst_data, NOP_INST);
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("a_valid", inst_valid, 1'b1);
      chk("a_pc", inst_pc, 32'(4 * i));
      chk("a_data", inst_data, mem_word(32'(4 * i)));
    end

    // Stall for six cycles from the first valid: queue fills, requests stop
    do_reset(1);
    step(); step(); step();
    chk("b_first_pc", inst_pc, 32'h0);
    stall = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("b_hold_pc", inst_pc, 32'h0);
      chk("b_hold_data", inst_data, mem_word(32'h0));
      if (k >= 2) chk1("b_req_off", imem_req_valid, 1'b0);
    end
    step();
    chk("b_hold_pc6", inst_pc, 32'h0);
    chk1("b_req_off6", imem_req_valid, 1'b0);
    chk("b_addr_next", imem_req_addr, 32'h10);
    stall = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk1("b_valid", inst_valid, 1'b1);
      chk("b_pc", inst_pc, 32'(4 * i));
      chk("b_data", inst_data, mem_word(32'(4 * i)));
    end

    // Memory not ready for three cycles at fetch_pc 0x20
    chk("c_addr0", imem_req_addr, 32'h20);
    imem_req_ready = 1'b0;
    step();
    chk("c_pc18", inst_pc, 32'h18);
    chk("c_addr1", imem_req_addr, 32'h20);
    chk1("c_req_valid", imem_req_valid, 1'b1);
    step();
    chk("c_pc1c", inst_pc, 32'h1C);
    chk("c_addr2", imem_req_addr, 32'h20);
    step();
    chk1("c_empty", inst_valid, 1'b0);
    chk("c_pc_hold", inst_pc, 32'h1C);
    chk("c_nop", inst_data, NOP_INST);
    chk("c_addr3", imem_req_addr, 32'h20);
    imem_req_ready = 1'b1;
    step();
    chk1("c_gap", inst_valid, 1'b0);
    step();
    chk("c_pc20", inst_pc, 32'h20);
    chk("c_data20", inst_data, mem_word(32'h20));
    step();
    chk("c_pc24", inst_pc, 32'h24);

    // Redirect to 0x103 with two requests in flight and one response arriving
    do_reset(3);
    repeat (4) step();
    chk1("d_lat3_valid", inst_valid, 1'b0);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    chk1("d_req_blocked", imem_req_valid, 1'b0);
    step();
    redirect = 1'b0;
    #1;
    chk1("d_flushed", inst_valid, 1'b0);
    chk("d_addr", imem_req_addr, 32'h100);
    chk1("d_req_resume", imem_req_valid, 1'b1);
    wait_valid("d_wait", 10);
    chk("d_pc100", inst_pc, 32'h100);
    chk("d_data100", inst_data, mem_word(32'h100));
    step();
    chk("d_pc104", inst_pc, 32'h104);
    chk("d_data104", inst_data, mem_word(32'h104));

    // Redirect while stalled with a full queue
    do_reset(1);
    stall = 1'b1;
    repeat (5) step();
    chk1("e_req_full", imem_req_valid, 1'b0);
    step();
    chk1("e_valid", inst_valid, 1'b1);
    chk("e_pc", inst_pc, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    #1;
    chk1("e_flushed", inst_valid, 1'b0);
    chk("e_addr", imem_req_addr, 32'h200);
    chk1("e_req_valid", imem_req_valid, 1'b1);
    wait_valid("e_wait", 10);
    chk("e_pc200", inst_pc, 32'h200);
    chk("e_data200", inst_data, mem_word(32'h200));
    stall = 1'b0;

    // Back-to-back redirects, second one to the top of memory with wrap
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    step();
    redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    #1;
    chk("f_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    chk1("f_req_valid", imem_req_valid, 1'b1);
    step();
    chk("f_addr_wrap", imem_req_addr, 32'h0);
    wait_valid("f_wait", 10);
    chk("f_pc_top", inst_pc, 32'hFFFF_FFFC);
    chk("f_data_top", inst_data, mem_word(32'hFFFF_FFFC));
    step();
    chk("f_pc_wrap", inst_pc, 32'h0);
    chk("f_data_wrap", inst_data, mem_word(32'h0));

    // Reset in the middle of a stream
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk1("g_inst_valid", inst_valid, 1'b0);
    chk1("g_req_valid", imem_req_valid, 1'b0);
    chk("g_addr", imem_req_addr, 32'h0);
    chk("g_inst_pc", inst_pc, 32'h0);
    chk("g_inst_data", inst_data, 32'h0);
    wait_valid("g_wait", 10);
    chk("g_pc0", inst_pc, 32'h0);
    chk("g_data0", inst_data, mem_word(32'h0));
    step();
    chk("g_pc4", inst_pc, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
